// File: rtl/conv_cfg_loader_pkg.sv
// Shared constants, state encoding and width helpers for the convolution
// configuration loader.
package conv_cfg_pkg;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DATA_WIDTH        = 32;
  localparam int DEF_ADDRESS_BITS      = 15;
  localparam int DEF_KERNAL_SIZE       = 5;
  localparam int DEF_IFM_DEPTH         = 3;
  localparam int DEF_NUMBER_OF_FILTERS = 6;
  localparam int DEF_NUMBER_OF_UNITS   = 3;

  localparam int WPF         = DEF_KERNAL_SIZE * DEF_KERNAL_SIZE * DEF_IFM_DEPTH;
  localparam int SLOTS       = DEF_NUMBER_OF_FILTERS / DEF_NUMBER_OF_UNITS;
  localparam int TOTAL_BEATS = DEF_NUMBER_OF_FILTERS * (WPF + 1);

  localparam int WORD_BITS = cnt_bits(WPF);
  localparam int UNIT_BITS = cnt_bits(DEF_NUMBER_OF_UNITS);
  localparam int SLOT_BITS = cnt_bits(SLOTS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_READY  = 2'd3;

endpackage

// File: rtl/conv_cfg_loader_if.sv
// Config word stream in, weight/bias memory write port out.
interface conv_cfg_loader_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 15,
  parameter int NU           = 3
);
  logic                    cfg_valid;
  logic [DATA_WIDTH-1:0]   cfg_data;
  logic                    cfg_ready;
  logic [DATA_WIDTH-1:0]   riscv_data;
  logic [ADDRESS_BITS-1:0] riscv_address;
  logic [NU-1:0]           wm_enable_write;
  logic [NU-1:0]           bm_enable_write;

  modport master (
    output cfg_valid, cfg_data,
    input  cfg_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write
  );

  modport slave (
    input  cfg_valid, cfg_data,
    output cfg_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write
  );
endinterface

// File: rtl/conv_cfg_addr_gen.sv
// Word/unit/slot counters that map the incoming beat to a unit and a local
// memory address; the slot base advances by WPF so no multiplier is needed.
module conv_cfg_addr_gen
  import conv_cfg_pkg::*;
#(
  parameter int WPF_P        = WPF,
  parameter int NU_P         = DEF_NUMBER_OF_UNITS,
  parameter int SLOTS_P      = SLOTS,
  parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
  parameter int UNIT_BITS_P  = cnt_bits(NU_P)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_bias,
  output logic [UNIT_BITS_P-1:0]  o_unit,
  output logic [ADDRESS_BITS-1:0] o_addr,
  output logic                    o_last_w,
  output logic                    o_last_b
);
  localparam int WB = cnt_bits(WPF_P);
  localparam int SB = cnt_bits(SLOTS_P);

  logic [WB-1:0]           r_word;
  logic [UNIT_BITS_P-1:0]  r_unit;
  logic [SB-1:0]           r_slot;
  logic [ADDRESS_BITS-1:0] r_base;
  logic                    w_word_last, w_unit_last, w_slot_last;

  assign w_word_last = (r_word == WB'(WPF_P - 1));
  assign w_unit_last = (r_unit == UNIT_BITS_P'(NU_P - 1));
  assign w_slot_last = (r_slot == SB'(SLOTS_P - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_unit <= '0;
      r_slot <= '0;
      r_base <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_unit <= '0;
      r_slot <= '0;
      r_base <= '0;
    end else if (i_en) begin
      // Bias beats step the unit every beat; weight beats only on word wrap.
      if (i_bias || w_word_last) begin
        r_word <= '0;
        if (w_unit_last) begin
          r_unit <= '0;
          if (w_slot_last) begin
            r_slot <= '0;
            r_base <= '0;
          end else begin
            r_slot <= r_slot + 1'b1;
            r_base <= r_base + ADDRESS_BITS'(WPF_P);
          end
        end else begin
          r_unit <= r_unit + 1'b1;
        end
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  assign o_unit   = r_unit;
  assign o_addr   = i_bias ? ADDRESS_BITS'(r_slot) : r_base + ADDRESS_BITS'(r_word);
  assign o_last_w = w_word_last & w_unit_last & w_slot_last;
  assign o_last_b = w_unit_last & w_slot_last;
endmodule

// File: rtl/conv_cfg_loader.sv
// Loads conv weights then biases from a valid/ready stream into per-unit
// WM/BM memories and flags conv_ready until the layer completes.
module conv_cfg_loader
  import conv_cfg_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS      = DEF_ADDRESS_BITS,
  parameter int KERNAL_SIZE       = DEF_KERNAL_SIZE,
  parameter int IFM_DEPTH         = DEF_IFM_DEPTH,
  parameter int NUMBER_OF_FILTERS = DEF_NUMBER_OF_FILTERS,
  parameter int NUMBER_OF_UNITS   = DEF_NUMBER_OF_UNITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic                     layer_end,
  conv_cfg_loader_if.slave         bus,
  output logic                     conv_ready,
  output logic                     busy
);
  localparam int NU      = NUMBER_OF_UNITS;
  localparam int WPF_L   = KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH;
  localparam int SLOTS_L = NUMBER_OF_FILTERS / NUMBER_OF_UNITS;
  localparam int UB      = cnt_bits(NU);

  logic [1:0]              r_state;
  logic                    w_load, w_bias, w_hs, w_clr, w_last_w, w_last_b;
  logic [UB-1:0]           w_unit;
  logic [ADDRESS_BITS-1:0] w_addr;
  logic [NU-1:0]           w_onehot;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [NU-1:0]           r_wm, r_bm;
  logic                    r_done, r_conv_ready;

  assign w_load   = (r_state == S_LOAD_W) || (r_state == S_LOAD_B);
  assign w_bias   = (r_state == S_LOAD_B);
  assign w_hs     = bus.cfg_valid && w_load;
  assign w_clr    = cfg_start && ((r_state == S_IDLE) || (r_state == S_READY));
  assign w_onehot = NU'(1) << w_unit;

  conv_cfg_addr_gen #(
    .WPF_P        (WPF_L),
    .NU_P         (NU),
    .SLOTS_P      (SLOTS_L),
    .ADDRESS_BITS (ADDRESS_BITS),
    .UNIT_BITS_P  (UB)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_en     (w_hs),
    .i_bias   (w_bias),
    .o_unit   (w_unit),
    .o_addr   (w_addr),
    .o_last_w (w_last_w),
    .o_last_b (w_last_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (cfg_start) r_state <= S_LOAD_W;
        S_LOAD_W: if (w_hs && w_last_w) r_state <= S_LOAD_B;
        S_LOAD_B: if (w_hs && w_last_b) r_state <= S_READY;
        S_READY: begin
          if (cfg_start)      r_state <= S_LOAD_W;
          else if (layer_end) r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data       <= '0;
      r_addr       <= '0;
      r_wm         <= '0;
      r_bm         <= '0;
      r_done       <= 1'b0;
      r_conv_ready <= 1'b0;
    end else begin
      r_wm   <= '0;
      r_bm   <= '0;
      r_done <= w_hs && w_bias && w_last_b;
      if (w_hs) begin
        r_data <= bus.cfg_data;
        r_addr <= w_addr;
        if (w_bias) r_bm <= w_onehot;
        else        r_wm <= w_onehot;
      end
      // r_done trails the final bias strobe so conv_ready lands one cycle later.
      if ((r_state == S_READY) && (cfg_start || layer_end)) r_conv_ready <= 1'b0;
      else if (r_done)                                       r_conv_ready <= 1'b1;
    end
  end

  assign bus.cfg_ready       = w_load;
  assign bus.riscv_data      = r_data;
  assign bus.riscv_address   = r_addr;
  assign bus.wm_enable_write = r_wm;
  assign bus.bm_enable_write = r_bm;
  assign busy                = w_load;
  assign conv_ready          = r_conv_ready;
endmodule

// File: tb/tb_conv_cfg_loader.sv
// Directed bench for conv_cfg_loader with a cycle-level reference model.
module tb_conv_cfg_loader;
  import conv_cfg_pkg::*;

  localparam int NU  = 3;
  localparam int NF  = 6;
  localparam int WP  = 75;
  localparam int TOT = NF * (WP + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_start = 1'b0;
  logic layer_end = 1'b0;
  logic conv_ready, busy;

  conv_cfg_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(15), .NU(NU)) bus ();

  conv_cfg_loader #(
    .DATA_WIDTH        (32),
    .ADDRESS_BITS      (15),
    .KERNAL_SIZE       (5),
    .IFM_DEPTH         (3),
    .NUMBER_OF_FILTERS (NF),
    .NUMBER_OF_UNITS   (NU)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .layer_end  (layer_end),
    .bus        (bus),
    .conv_ready (conv_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_strobe = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: 0 idle, 1 loading, 2 ready.
  int          ms = 0;
  int          beat = 0;
  logic [2:0]  e_wm = '0, e_bm = '0;
  int          e_addr = 0;
  logic [31:0] e_data = '0;
  logic        e_cr = 1'b0, fin = 1'b0;

  always @(posedge clk) begin : model
    logic hs, nxt_cr;
    int f, w, b;
    if (!reset) begin
      ms = 0; beat = 0; e_wm = '0; e_bm = '0; e_addr = 0; e_data = '0; e_cr = 1'b0; fin = 1'b0;
    end else begin
      hs = bus.cfg_valid && (ms == 1);
      nxt_cr = e_cr;
      if (fin) nxt_cr = 1'b1;
      if (ms == 2 && (cfg_start || layer_end)) nxt_cr = 1'b0;
      fin = 1'b0;
      e_wm = '0;
      e_bm = '0;
      if (hs) begin
        if (beat < NF * WP) begin
          f = beat / WP; w = beat % WP;
          e_wm = 3'(1 << (f % NU));
          e_addr = (f / NU) * WP + w;
        end else begin
          b = beat - NF * WP;
          e_bm = 3'(1 << (b % NU));
          e_addr = b / NU;
        end
        e_data = bus.cfg_data;
        beat++;
        if (beat == TOT) begin ms = 2; fin = 1'b1; end
      end else if (ms == 0 && cfg_start) begin
        ms = 1; beat = 0;
      end else if (ms == 2) begin
        if (cfg_start)      begin ms = 1; beat = 0; end
        else if (layer_end) ms = 0;
      end
      e_cr = nxt_cr;
    end
  end

  always @(negedge clk) begin : monitor
    logic ld;
    ld = reset && (ms == 1);
    check_val("cfg_ready", bus.cfg_ready, ld);
    check_val("busy", busy, ld);
    check_val("wm", bus.wm_enable_write, reset ? e_wm : 3'b0);
    check_val("bm", bus.bm_enable_write, reset ? e_bm : 3'b0);
    check_val("addr", bus.riscv_address, reset ? e_addr : 0);
    check_val("data", bus.riscv_data, reset ? e_data : 32'd0);
    check_val("conv_ready", conv_ready, reset ? e_cr : 1'b0);
    n_strobe += int'((bus.wm_enable_write | bus.bm_enable_write) != 0);
  end

  task automatic pulse_start();
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
  endtask

  task automatic load(input int n_beats, input bit rnd, input bit inject);
    int i = 0;
    while (i < n_beats) begin
      @(negedge clk);
      bus.cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.cfg_data  = i;
      cfg_start     = inject && bus.cfg_valid && (i == 50);
      layer_end     = inject && bus.cfg_valid && (i == 60);
      @(posedge clk); #1;
      if (bus.cfg_valid) begin
        case (i)
          0:   begin check_val("b0_wm", bus.wm_enable_write, 3'b001);
                     check_val("b0_addr", bus.riscv_address, 0); end
          74:  begin check_val("b74_wm", bus.wm_enable_write, 3'b001);
                     check_val("b74_addr", bus.riscv_address, 74); end
          75:  begin check_val("b75_wm", bus.wm_enable_write, 3'b010);
                     check_val("b75_addr", bus.riscv_address, 0); end
          300: begin check_val("b300_wm", bus.wm_enable_write, 3'b010);
                     check_val("b300_addr", bus.riscv_address, 75);
                     check_val("b300_data", bus.riscv_data, 300); end
          450: begin check_val("b450_bm", bus.bm_enable_write, 3'b001);
                     check_val("b450_addr", bus.riscv_address, 0); end
          455: begin check_val("b455_bm", bus.bm_enable_write, 3'b100);
                     check_val("b455_wm", bus.wm_enable_write, 3'b000);
                     check_val("b455_addr", bus.riscv_address, 1); end
          default: ;
        endcase
        i++;
      end
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    cfg_start     = 1'b0;
    layer_end     = 1'b0;
  endtask

  task automatic check_ready_rise();
    check_val("cr_pre", conv_ready, 1'b0);
    @(posedge clk); #1;
    check_val("cr_rise", conv_ready, 1'b1);
    check_val("ready_busy", busy, 1'b0);
  endtask

  initial begin
    int s0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Valid without start is ignored.
    @(negedge clk) bus.cfg_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("idle_ready", bus.cfg_ready, 1'b0);
      check_val("idle_wm", bus.wm_enable_write, 3'b0);
      check_val("idle_cr", conv_ready, 1'b0);
    end
    @(negedge clk) bus.cfg_valid = 1'b0;

    // Full load, valid held.
    pulse_start();
    check_val("busy_ld", busy, 1'b1);
    load(TOT, 1'b0, 1'b0);
    check_ready_rise();

    // Reload from READY under random backpressure.
    pulse_start();
    check_val("reload_cr", conv_ready, 1'b0);
    s0 = n_strobe;
    load(TOT, 1'b1, 1'b0);
    check_ready_rise();
    check_val("strobe_cnt", n_strobe - s0, TOT);

    // layer_end retires weights.
    @(negedge clk) layer_end = 1'b1;
    @(negedge clk) layer_end = 1'b0;
    check_val("le_cr", conv_ready, 1'b0);
    check_val("le_ready", bus.cfg_ready, 1'b0);

    pulse_start();
    load(TOT, 1'b0, 1'b0);
    check_ready_rise();

    // start and layer_end together: start wins.
    @(negedge clk) begin cfg_start = 1'b1; layer_end = 1'b1; end
    @(negedge clk) begin cfg_start = 1'b0; layer_end = 1'b0; end
    check_val("both_ready", bus.cfg_ready, 1'b1);
    check_val("both_cr", conv_ready, 1'b0);

    // Reset mid-load.
    load(100, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_val("rst_ready", bus.cfg_ready, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wm", bus.wm_enable_write, 3'b0);
    check_val("rst_bm", bus.bm_enable_write, 3'b0);
    check_val("rst_addr", bus.riscv_address, 0);
    check_val("rst_data", bus.riscv_data, 0);
    check_val("rst_cr", conv_ready, 1'b0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;

    // Ignored start/layer_end mid-load.
    pulse_start();
    load(TOT, 1'b0, 1'b1);
    check_ready_rise();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_cfg_loader.md
Name: conv_cfg_loader

Overview:
- Configuration sequencer for the convolution block's weight and bias memories.
- Accepts a single valid/ready word stream from the RISC-V side.
- Scatters each word to the correct unit's weight memory (WM) or bias memory (BM) by generating data, address and one-hot write strobes.
- Raises conv_ready once all filters and biases are loaded, and holds it until the layer reports completion.

Parameters:
DATA_WIDTH, 32, word width of stream and memories
ADDRESS_BITS, 15, width of riscv_address
KERNAL_SIZE, 5, kernel edge length
IFM_DEPTH, 3, input feature-map channels
NUMBER_OF_FILTERS, 6, total filters (NF); must be a multiple of NUMBER_OF_UNITS
NUMBER_OF_UNITS, 3, parallel conv units (NU)
WPF (derived), KERNAL_SIZE*KERNAL_SIZE*IFM_DEPTH = 75, weight words per filter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_start  in  1  single-cycle pulse; begins a full reload
cfg_valid  in  1  stream word valid
cfg_data  in  DATA_WIDTH  stream word
cfg_ready  out  1  loader accepts a word this cycle
riscv_data  out  DATA_WIDTH  write data to WM/BM
riscv_address  out  ADDRESS_BITS  write address within the selected unit memory
wm_enable_write  out  NU  one-hot WM write strobe
bm_enable_write  out  NU  one-hot BM write strobe
conv_ready  out  1  weights valid; the conv block may run
layer_end  in  1  single-cycle pulse; layer finished and weights may be retired
busy  out  1  load in progress

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0 and all counters are 0.
- FSM states and transitions:
  - IDLE: cfg_start -> LOAD_W.
  - LOAD_W: the final weight handshake -> LOAD_B.
  - LOAD_B: the final bias handshake -> READY.
  - READY: layer_end -> IDLE; cfg_start -> LOAD_W (reload).
- cfg_ready = 1 exactly in LOAD_W and LOAD_B, driven combinationally from state. busy is likewise high in LOAD_W and LOAD_B.
- A handshake occurs when cfg_valid && cfg_ready. Stalls of any length are allowed. cfg_valid outside LOAD_W/LOAD_B is ignored.
- Stream order:
  - NF*WPF weights first: filter f = 0..NF-1, word w = 0..WPF-1 within each filter.
  - Then NF biases, b = 0..NF-1.
- Weight mapping: unit u = f mod NU, slot s = f div NU, address = s*WPF + w.
- Bias mapping: unit u = b mod NU, address = b div NU.
- Counters:
  - w wraps WPF-1 -> 0 and increments u.
  - u wraps NU-1 -> 0 and increments s.
  - No multiplier and no divider is used.
- Write latency: riscv_data, riscv_address and the strobes are registered. They are visible for exactly one cycle, in the cycle after the handshake. Strobes are 0 in cycles with no handshake.
- Strobe exclusivity: at most one bit of wm_enable_write | bm_enable_write is set in any cycle.
- Between writes, riscv_data and riscv_address hold their last value.
- conv_ready:
  - Registered.
  - Rises in the cycle after the final bias write strobe (two cycles after the final handshake).
  - Stays high until layer_end or cfg_start is sampled, then falls on the next edge.
- cfg_start handling:
  - cfg_start in LOAD_W/LOAD_B is ignored; the load continues.
  - cfg_start together with layer_end in READY: cfg_start wins, and the FSM goes to LOAD_W.
  - Every entry to LOAD_W clears all counters.
- layer_end in IDLE/LOAD_W/LOAD_B is ignored.
- Reset mid-load: state returns to IDLE and counters clear. A partially loaded memory is not flagged; software must issue cfg_start again.
- Total handshakes per load = NF*(WPF+1) = 456 with default parameters.

Decomposition:
- Package conv_cfg_pkg holds:
  - the state encoding (IDLE, LOAD_W, LOAD_B, READY);
  - the derived constants WPF, SLOTS = NF/NU, TOTAL_BEATS;
  - the counter widths computed with $clog2.
- One sub-module, conv_cfg_addr_gen, contains the w/u/s and bias counters. It produces the unit index, local address and last-weight/last-bias flags on a handshake enable. The top level contains the FSM, output registers and conv_ready.

Test Plan:
1. Reset/idle: hold reset=0 then release. Then pulse cfg_valid=1 without cfg_start -> cfg_ready=0, no strobes, conv_ready=0.
2. Full load with cfg_valid held high and data = beat index:
   - Beat 0 -> wm_enable_write=001, addr 0.
   - Beat 300 (f=4, w=0) -> wm_enable_write=010, addr 75, data 300.
   - Beat 455 (bias 5) -> bm_enable_write=100, addr 1.
   - conv_ready rises two cycles after beat 455.
3. Backpressure: toggle cfg_valid randomly at 50% -> strobe count equals handshake count, addresses match scenario 2, no strobe in idle cycles.
4. Layer end and reload:
   - layer_end in READY -> conv_ready=0 the next cycle.
   - cfg_start in READY -> LOAD_W, and the first strobe targets unit 0, addr 0.
   - cfg_start+layer_end in the same cycle -> LOAD_W.
5. Reset mid-load: assert reset after 100 beats -> all outputs 0 immediately. After cfg_start, the first write is addr 0 on unit 0.
6. Ignored events: cfg_start at beat 50 and layer_end at beat 60 -> load completes unchanged at 456 beats.
